// File: rtl/ikaopll_bus_writer.sv
// Host-side write initiator for the IKAOPLL core: queues (addr,data) register writes
// and plays each one out as a YM2413 address cycle plus data cycle with post-write waits.
module ikaopll_bus_writer #(
  parameter int STROBE_LEN = 2,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_EMUCLK,
  input  logic                        i_RST_n,
  input  logic                        i_phiM_PCEN_n,
  input  logic                        i_REQ_VALID,
  output logic                        o_REQ_READY,
  input  logic [7:0]                  i_REQ_ADDR,
  input  logic [7:0]                  i_REQ_DATA,
  output logic                        o_CS_n,
  output logic                        o_WR_n,
  output logic                        o_A0,
  output logic [7:0]                  o_D,
  output logic                        o_BUSY,
  output logic [$clog2(FIFO_DEPTH):0] o_FIFO_LVL
);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_LVL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  STRB_LOAD = 4'(STROBE_LEN - 1);
  localparam logic [7:0]  AW_LOAD   = 8'(ADDR_WAIT - 1);
  localparam logic [7:0]  DW_LOAD   = 8'(DATA_WAIT - 1);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STRB, A_HOLD, A_WAIT, D_SETUP, D_STRB, D_HOLD, D_WAIT
  } state_t;

  state_t        state;
  logic [7:0]    fifo_addr [FIFO_DEPTH];
  logic [7:0]    fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   lvl, lvl_next;
  logic [3:0]    strb_cnt;
  logic [7:0]    wait_cnt;
  logic [7:0]    data_q;
  logic          tick, push, pop;
  logic [7:0]    head_addr, head_data;

  // Handshake: a request transfers on any i_EMUCLK edge where i_REQ_VALID and
  // o_REQ_READY are both 1; ADDR/DATA must be stable then, READY never depends on VALID.
  always_comb begin
    tick      = !i_phiM_PCEN_n;
    push      = i_REQ_VALID && o_REQ_READY;
    pop       = tick && (lvl != '0) &&
                ((state == IDLE) ||
                 (((state == D_HOLD) || (state == D_WAIT)) && (wait_cnt == 8'd0)));
    head_addr = fifo_addr[rd_ptr];
    head_data = fifo_data[rd_ptr];
    lvl_next  = lvl;
    case ({push, pop})
      2'b10:   lvl_next = lvl + 1'b1;
      2'b01:   lvl_next = lvl - 1'b1;
      default: lvl_next = lvl;
    endcase
  end

  assign o_BUSY     = (state != IDLE) || (lvl != '0);
  assign o_FIFO_LVL = lvl;

  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      lvl         <= '0;
      o_REQ_READY <= 1'b0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= i_REQ_ADDR;
        fifo_data[wr_ptr] <= i_REQ_DATA;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      lvl         <= lvl_next;
      o_REQ_READY <= (lvl_next != FULL_LVL);
    end
  end

  // Outputs are assigned on the transition into each state, so they are registered.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      state    <= IDLE;
      o_CS_n   <= 1'b1;
      o_WR_n   <= 1'b1;
      o_A0     <= 1'b0;
      o_D      <= 8'h00;
      strb_cnt <= 4'd0;
      wait_cnt <= 8'd0;
      data_q   <= 8'h00;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (pop) begin
            data_q <= head_data;
            o_D    <= head_addr;
            o_A0   <= 1'b0;
            o_CS_n <= 1'b0;
            state  <= A_SETUP;
          end
        end
        A_SETUP: begin
          o_WR_n   <= 1'b0;
          strb_cnt <= STRB_LOAD;
          state    <= A_STRB;
        end
        A_STRB: begin
          if (strb_cnt == 4'd0) begin
            o_WR_n   <= 1'b1;
            wait_cnt <= AW_LOAD;
            state    <= A_HOLD;
          end else begin
            strb_cnt <= strb_cnt - 1'b1;
          end
        end
        A_HOLD, A_WAIT: begin
          if (wait_cnt == 8'd0) begin
            o_CS_n <= 1'b0;
            o_A0   <= 1'b1;
            o_D    <= data_q;
            state  <= D_SETUP;
          end else begin
            o_CS_n   <= 1'b1;
            wait_cnt <= wait_cnt - 1'b1;
            state    <= A_WAIT;
          end
        end
        D_SETUP: begin
          o_WR_n   <= 1'b0;
          strb_cnt <= STRB_LOAD;
          state    <= D_STRB;
        end
        D_STRB: begin
          if (strb_cnt == 4'd0) begin
            o_WR_n   <= 1'b1;
            wait_cnt <= DW_LOAD;
            state    <= D_HOLD;
          end else begin
            strb_cnt <= strb_cnt - 1'b1;
          end
        end
        D_HOLD, D_WAIT: begin
          if (wait_cnt != 8'd0) begin
            o_CS_n   <= 1'b1;
            wait_cnt <= wait_cnt - 1'b1;
            state    <= D_WAIT;
          end else if (pop) begin
            // Next request chains straight into its address cycle.
            data_q <= head_data;
            o_D    <= head_addr;
            o_A0   <= 1'b0;
            o_CS_n <= 1'b0;
            state  <= A_SETUP;
          end else begin
            o_CS_n <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          o_CS_n <= 1'b1;
          o_WR_n <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule
